// File: rtl/bram_input_1x1_reader_pkg.sv
// Shared types and helpers for the 1x1-conv input BRAM reader.
//   rd_state_e : reader sequencer states
//   beat_tag_t : per-beat tags carried next to the pixel word
//   pix_count / addr_w / word_w : size helpers used for derived localparams
package bram_input_1x1_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_e;

  typedef struct packed {
    logic last_pixel;
    logic last;
  } beat_tag_t;

  localparam int TAG_W = 2;

  function automatic int pix_count(input int w, input int h);
    return w * h;
  endfunction

  // Never returns 0 so single-entry ranges still get a 1-bit register.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int word_w(input int dw, input int ch);
    return dw * ch;
  endfunction

endpackage

// File: rtl/bram_input_1x1_reader_if.sv
// Bus bundle between the reader, its BRAM read port and the conv datapath.
//   rd_addr/rd_en/rd_data           : BRAM read port
//   o_data/o_valid/o_ready          : pixel stream to the consumer
//   o_last_pixel/o_last             : beat tags (end of pass / end of job)
// master = reader side, slave = BRAM + consumer side.
interface bram_input_1x1_reader_if #(
  parameter int ADDR_W = 5,
  parameter int WORD_W = 24
) ();
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;
  logic [WORD_W-1:0] rd_data;
  logic [WORD_W-1:0] o_data;
  logic              o_valid;
  logic              o_ready;
  logic              o_last_pixel;
  logic              o_last;

  modport master (
    output rd_addr, rd_en, o_data, o_valid, o_last_pixel, o_last,
    input  rd_data, o_ready
  );

  modport slave (
    input  rd_addr, rd_en, o_data, o_valid, o_last_pixel, o_last,
    output rd_data, o_ready
  );
endinterface

// File: rtl/bram_input_1x1_reader_skid_fifo.sv
// Two-entry FIFO between the BRAM capture point and the output stream.
//   clk, rst_n : clock, async active-low reset (contents cleared to zero)
//   push_i     : write wdata_i this cycle (caller guarantees space)
//   pop_i      : drop the head entry this cycle (caller guarantees valid_o)
//   rdata_o    : head entry, valid_o : non-empty, count_o : occupancy 0..2
module bram_reader_skid_fifo
  import bram_input_1x1_reader_pkg::*;
#(
  parameter int WIDTH = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             valid_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wptr_q;
  logic             rptr_q;
  logic [1:0]       cnt_q;
  logic [1:0]       cnt_d;

  assign cnt_d = cnt_q + {1'b0, push_i} - {1'b0, pop_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      // A push into a full FIFO only happens together with a pop, and then
      // the write slot is the head being retired at this same edge.
      if (push_i) begin
        mem_q[wptr_q] <= wdata_i;
        wptr_q        <= ~wptr_q;
      end
      if (pop_i) begin
        rptr_q <= ~rptr_q;
      end
      cnt_q <= cnt_d;
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign valid_o = (cnt_q != 2'd0);
  assign count_o = cnt_q;

endmodule

// File: rtl/bram_input_1x1_reader.sv
// Read-side sequencer for the 1x1-conv input feature-map BRAM.
// Sweeps pixel addresses 0..N-1 (N = IN_WIDTH*IN_HEIGHT) NUM_PASSES times per
// start, absorbs the BRAM read latency (0 or 1) and streams each packed pixel
// word on a valid/ready interface through a 2-entry skid FIFO.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : one-cycle pulse, accepted only when idle
//   busy         : high from the cycle after an accepted start until done
//   done         : one-cycle pulse the cycle after the o_last beat is taken
//   stall_cycles : (only with BRAM_READER_STALL_CNT_EN) busy cycles with
//                  o_valid && !o_ready, cleared on start, saturating
//   bus          : BRAM read port + output stream (master modport)
// Optional feature macro: BRAM_READER_STALL_CNT_EN
module bram_input_1x1_reader
  import bram_input_1x1_reader_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int IN_CHANNELS  = 3,
  parameter int IN_WIDTH     = 5,
  parameter int IN_HEIGHT    = 5,
  parameter int READ_LATENCY = 0,
  parameter int NUM_PASSES   = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy,
  output logic done,
`ifdef BRAM_READER_STALL_CNT_EN
  output logic [31:0] stall_cycles,
`endif
  bram_input_1x1_reader_if.master bus
);

  localparam int N  = pix_count(IN_WIDTH, IN_HEIGHT);
  localparam int AW = addr_w(N);
  localparam int PW = addr_w(NUM_PASSES);
  localparam int WW = word_w(DATA_WIDTH, IN_CHANNELS);

  rd_state_e        state_q;
  logic [AW-1:0]    pix_q, pix_d;
  logic [PW-1:0]    pass_q;
  logic             busy_q, done_q;

  logic             pop, push, infl, rd_en_c;
  logic             last_pix_c, last_pass_c;
  logic [2:0]       credit_used;
  beat_tag_t        rd_tag, push_tag, head_tag;
  logic [WW+1:0]    fifo_wdata, fifo_rdata;
  logic             fifo_valid;
  logic [1:0]       fifo_count;

  assign pop         = fifo_valid && bus.o_ready;
  assign last_pix_c  = (pix_q == AW'(N - 1));
  assign last_pass_c = (pass_q == PW'(NUM_PASSES - 1));
  assign pix_d       = last_pix_c ? '0 : pix_q + AW'(1);

  // Entries held plus reads still on their way, after this cycle's pop.
  assign credit_used = {1'b0, fifo_count} + {2'b0, infl} - {2'b0, pop};
  assign rd_en_c     = (state_q == ST_RUN) && (credit_used < 3'd2);

  always_comb begin
    rd_tag            = '0;
    rd_tag.last_pixel = last_pix_c;
    rd_tag.last       = last_pix_c && last_pass_c;
  end

  generate
    if (READ_LATENCY == 0) begin : g_rl0
      // Combinational BRAM port: the word is on rd_data while rd_en is high.
      assign infl     = 1'b0;
      assign push     = rd_en_c;
      assign push_tag = rd_tag;
    end else begin : g_rl1
      // Registered BRAM port: the word arrives one cycle after rd_en, so the
      // tags ride along with the in-flight flag.
      logic      infl_q;
      beat_tag_t tag_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          infl_q <= 1'b0;
          tag_q  <= '0;
        end else begin
          infl_q <= rd_en_c;
          tag_q  <= rd_tag;
        end
      end
      assign infl     = infl_q;
      assign push     = infl_q;
      assign push_tag = tag_q;
    end
  endgenerate

  assign fifo_wdata = {push_tag, bus.rd_data};

  bram_reader_skid_fifo #(
    .WIDTH (WW + TAG_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (fifo_wdata),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .valid_o (fifo_valid),
    .count_o (fifo_count)
  );

  assign head_tag = fifo_rdata[WW+1:WW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pix_q   <= '0;
      pass_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_RUN;
            pix_q   <= '0;
            pass_q  <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (rd_en_c) begin
            pix_q <= pix_d;
            if (last_pix_c) begin
              if (last_pass_c) begin
                pass_q  <= '0;
                state_q <= ST_DRAIN;
              end else begin
                pass_q <= pass_q + PW'(1);
              end
            end
          end
        end
        ST_DRAIN: begin
          // The job's final beat is the last entry ever written, so taking
          // it means the FIFO is empty and nothing is in flight.
          if (pop && head_tag.last) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef BRAM_READER_STALL_CNT_EN
  logic [31:0] stall_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (state_q == ST_IDLE && start) begin
      stall_q <= '0;
    end else if (busy_q && fifo_valid && !bus.o_ready && stall_q != '1) begin
      stall_q <= stall_q + 32'd1;
    end
  end
  assign stall_cycles = stall_q;
`endif

  assign busy             = busy_q;
  assign done             = done_q;
  assign bus.rd_en        = rd_en_c;
  assign bus.rd_addr      = pix_q;
  assign bus.o_data       = fifo_rdata[WW-1:0];
  assign bus.o_valid      = fifo_valid;
  assign bus.o_last_pixel = fifo_valid && head_tag.last_pixel;
  assign bus.o_last       = fifo_valid && head_tag.last;

endmodule

// File: tb/tb_bram_input_1x1_reader.sv
// Bench for bram_input_1x1_reader: two instances side by side
// (instance 0: READ_LATENCY=0, NUM_PASSES=1; instance 1: READ_LATENCY=1,
// NUM_PASSES=2) sharing start, o_ready and rst_n, each with its own BRAM model.
module tb_bram_input_1x1_reader;

  localparam int DW = 8;
  localparam int CH = 3;
  localparam int IW = 5;
  localparam int IH = 5;
  localparam int N  = IW * IH;
  localparam int AW = 5;
  localparam int WW = DW * CH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, ordy;
  logic [1:0]    busy_a, done_a, rden_a, ov_a, olp_a, ol_a;
  logic [AW-1:0] addr_a [2];
  logic [WW-1:0] od_a   [2];
`ifdef BRAM_READER_STALL_CNT_EN
  logic [31:0]   stall_a [2];
`endif

  // Pixel p holds channel c value 3p+c, channel 0 in the LSBs.
  function automatic logic [WW-1:0] word(input int p);
    logic [7:0] c0, c1, c2;
    c0 = 8'(3 * p);
    c1 = 8'(3 * p + 1);
    c2 = 8'(3 * p + 2);
    return {c2, c1, c0};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    bram_input_1x1_reader_if #(.ADDR_W(AW), .WORD_W(WW)) bif ();

    assign bif.o_ready = ordy;

    if (g == 0) begin : g_comb
      assign bif.rd_data = bif.rd_en ? word(int'(bif.rd_addr)) : '0;
    end else begin : g_reg
      logic [WW-1:0] bram_q;
      always_ff @(posedge clk) bram_q <= bif.rd_en ? word(int'(bif.rd_addr)) : '0;
      assign bif.rd_data = bram_q;
    end

    bram_input_1x1_reader #(
      .DATA_WIDTH  (DW),
      .IN_CHANNELS (CH),
      .IN_WIDTH    (IW),
      .IN_HEIGHT   (IH),
      .READ_LATENCY(g),
      .NUM_PASSES  (g + 1)
    ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .busy        (busy_a[g]),
      .done        (done_a[g]),
`ifdef BRAM_READER_STALL_CNT_EN
      .stall_cycles(stall_a[g]),
`endif
      .bus         (bif)
    );

    assign rden_a[g] = bif.rd_en;
    assign addr_a[g] = bif.rd_addr;
    assign od_a[g]   = bif.o_data;
    assign ov_a[g]   = bif.o_valid;
    assign olp_a[g]  = bif.o_last_pixel;
    assign ol_a[g]   = bif.o_last;
  end

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model state, one slot per instance.
  int            rd_cnt [2], beat_cnt [2], start_cyc [2], done_cyc [2];
  int            beats_done [2], stall_exp [2];
  bit            active [2], done_next [2], prev_stall [2], first_seen [2];
  logic [WW-1:0] prev_data [2], first_beat [2], last_beat [2];
  logic          prev_lp [2], prev_l [2];

  task automatic chk(input string name, input int idx, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  // Compare all observable outputs for the current cycle at the falling edge,
  // advance the model, then return just after the next rising edge.
  task automatic step();
    @(negedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      int total;
      int k;
      bit pop;
      total = N * (i + 1);
      if (!rst_n) begin
        chk("rst_busy", i, busy_a[i], 0);
        chk("rst_done", i, done_a[i], 0);
        chk("rst_rd_en", i, rden_a[i], 0);
        chk("rst_rd_addr", i, addr_a[i], 0);
        chk("rst_o_valid", i, ov_a[i], 0);
        chk("rst_o_data", i, od_a[i], 0);
        chk("rst_o_last_pixel", i, olp_a[i], 0);
        chk("rst_o_last", i, ol_a[i], 0);
`ifdef BRAM_READER_STALL_CNT_EN
        chk("rst_stall_cycles", i, stall_a[i], 0);
`endif
        active[i]     = 0;
        done_next[i]  = 0;
        prev_stall[i] = 0;
        stall_exp[i]  = 0;
        first_seen[i] = 1;
        continue;
      end
      pop = ov_a[i] && ordy;
      chk("done", i, done_a[i], done_next[i]);
      if (done_a[i]) done_cyc[i] = cyc;
      chk("busy", i, busy_a[i], active[i]);
`ifdef BRAM_READER_STALL_CNT_EN
      chk("stall_cycles", i, stall_a[i], stall_exp[i]);
`endif
      if (rden_a[i]) begin
        chk("rd_addr", i, addr_a[i], rd_cnt[i] % N);
        chk("credit", i, (rd_cnt[i] - beat_cnt[i] - int'(pop)) < 2, 1);
        chk("read_in_job", i, active[i] && rd_cnt[i] < total, 1);
        rd_cnt[i]++;
      end
      if (prev_stall[i]) begin
        chk("hold_valid", i, ov_a[i], 1);
        chk("hold_data", i, od_a[i], prev_data[i]);
        chk("hold_last_pixel", i, olp_a[i], prev_lp[i]);
        chk("hold_last", i, ol_a[i], prev_l[i]);
      end
      if (ov_a[i]) chk("valid_in_job", i, active[i], 1);
      if (ov_a[i] && !first_seen[i]) begin
        chk("latency", i, cyc - start_cyc[i], 2 + i);
        first_seen[i] = 1;
      end
      done_next[i] = 0;
      if (pop) begin
        k = beat_cnt[i];
        chk("o_data", i, od_a[i], word(k % N));
        chk("o_last_pixel", i, olp_a[i], (k % N) == N - 1);
        chk("o_last", i, ol_a[i], k == total - 1);
        if (k == 0) first_beat[i] = od_a[i];
        last_beat[i] = od_a[i];
        beat_cnt[i]++;
        if (k == total - 1) done_next[i] = 1;
      end
      if (active[i] && ov_a[i] && !ordy) stall_exp[i]++;
      prev_stall[i] = ov_a[i] && !ordy;
      prev_data[i]  = od_a[i];
      prev_lp[i]    = olp_a[i];
      prev_l[i]     = ol_a[i];
      if (start && !active[i]) begin
        active[i]     = 1;
        rd_cnt[i]     = 0;
        beat_cnt[i]   = 0;
        start_cyc[i]  = cyc;
        first_seen[i] = 0;
        stall_exp[i]  = 0;
      end else if (done_next[i]) begin
        active[i]     = 0;
        beats_done[i] = beat_cnt[i];
      end
    end
    @(posedge clk);
    #1;
  endtask

  // mode 0: o_ready high; mode 1: o_ready high plus a stray start mid-job;
  // mode 2: random o_ready and random stray starts while both jobs run.
  task automatic run_to_end(input int budget, input int mode);
    int n;
    n = 0;
    while ((active[0] || active[1]) && n < budget) begin
      case (mode)
        1:       begin ordy = 1'b1; start = (n == 10); end
        2:       begin
                   ordy  = 1'($urandom_range(0, 1));
                   start = active[0] && active[1] && ($urandom_range(0, 15) == 0);
                 end
        default: begin ordy = 1'b1; start = 1'b0; end
      endcase
      step();
      n++;
    end
    start = 1'b0;
    ordy  = 1'b1;
    step();
    chk("job_timeout", 0, active[0] || active[1], 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    ordy  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rd_cnt[i] = 0; beat_cnt[i] = 0; start_cyc[i] = 0; done_cyc[i] = 0;
      beats_done[i] = 0; stall_exp[i] = 0; active[i] = 0; done_next[i] = 0;
      prev_stall[i] = 0; first_seen[i] = 1; prev_data[i] = '0;
      first_beat[i] = '0; last_beat[i] = '0; prev_lp[i] = 0; prev_l[i] = 0;
    end
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Full-rate job with a stray start while running.
    start = 1'b1;
    step();
    start = 1'b0;
    run_to_end(300, 1);
    chk("beats", 0, beats_done[0], 25);
    chk("beats", 1, beats_done[1], 50);
    chk("first_beat", 0, first_beat[0], 24'h020100);
    chk("last_beat", 0, last_beat[0], 24'h4A4948);
    chk("last_beat", 1, last_beat[1], 24'h4A4948);
    chk("job_len", 0, done_cyc[0] - start_cyc[0], 27);
    chk("job_len", 1, done_cyc[1] - start_cyc[1], 53);

    // Random back-pressure.
    start = 1'b1;
    step();
    start = 1'b0;
    run_to_end(2000, 2);
    chk("beats_rand", 0, beats_done[0], 25);
    chk("beats_rand", 1, beats_done[1], 50);

    // Consumer blocked right after start: only two reads may be issued.
    start = 1'b1;
    ordy  = 1'b0;
    step();
    start = 1'b0;
    repeat (10) step();
    chk("reads_blocked", 0, rd_cnt[0], 2);
    chk("reads_blocked", 1, rd_cnt[1], 2);
    run_to_end(300, 0);
    chk("beats_blocked", 0, beats_done[0], 25);
    chk("beats_blocked", 1, beats_done[1], 50);

    // Asynchronous reset after ten beats, then a fresh job.
    start = 1'b1;
    step();
    start = 1'b0;
    for (int n = 0; n < 100 && beat_cnt[0] < 10; n++) step();
    chk("reach_beat10", 0, beat_cnt[0], 10);
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    run_to_end(300, 0);
    chk("beats_after_rst", 0, beats_done[0], 25);
    chk("beats_after_rst", 1, beats_done[1], 50);
    chk("first_after_rst", 0, first_beat[0], 24'h020100);
    chk("first_after_rst", 1, first_beat[1], 24'h020100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
